seq_detect_fsm: RTL and testbench
=================================

# seq_detect_fsm

Parametrised serial bit-pattern detector. It generalises the fixed 3-state `fsm` to an N-bit pattern with an input-valid qualifier, KMP-style fallback on mismatch, and selectable overlapping or non-overlapping detection. It sits on a serial bit stream and emits a registered one-cycle `out` pulse per detected pattern. It exposes `state` and `next_state` for debug, the same way `fsm` does.

## Interface
- `PATTERN_LEN`, default 4: pattern length in bits, ≥2.
- `PATTERN`, default 4'b1011: pattern; `PATTERN[PATTERN_LEN-1]` is the first bit expected.
- `OVERLAP`, default 1: 1 = overlapping matches allowed, 0 = restart from empty after a match.
- `CNT_W`, default 8: width of `match_count`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in` input, 1 bit: serial data bit.
- `in_valid` input, 1 bit: `in` is consumed on this clock edge.
- `state` output, `ST_W = $clog2(PATTERN_LEN)` bits: registered count of pattern bits currently matched (0..PATTERN_LEN-1).
- `next_state` output, `ST_W` bits: combinational next value of `state`.
- `out` output, 1 bit: registered match pulse.
- `match_count` output, `CNT_W` bits: saturating match counter (see Configuration).

## Operation
- **Reset:** `state`=0, `out`=0, `match_count`=0. Reset overrides `in_valid`; a partial match in progress is discarded.
- **`in_valid`=0:** `next_state`=`state`, `state` holds, `out`=0 on the next edge.
- **`in_valid`=1, let k=`state`:**
  - If `in` equals pattern bit k (counting from the MSB) and k<PATTERN_LEN-1: `next_state`=k+1.
  - If `in` equals pattern bit k and k=PATTERN_LEN-1, this is a match:
    - `out`=1 on the next edge.
    - `next_state` = B when OVERLAP=1, where B is the length of the longest proper prefix of PATTERN that is also its suffix. `next_state` = 0 when OVERLAP=0.
  - Otherwise (mismatch): `next_state` = length of the longest suffix of (first k pattern bits followed by `in`) that is a prefix of PATTERN. This can be nonzero. No match is reported.
- Compute the transition function at elaboration time (function or generate). No runtime tables.
- `out` is high only for the single cycle after the edge that accepted the final pattern bit. Back-to-back matches produce back-to-back pulses.

## Timing
- `next_state` is combinational from `state`, `in`, `in_valid`, with zero latency.
- `state`, `out` and `match_count` update on the rising edge of `clk`.
- Match latency: `out` is asserted in the cycle immediately after the edge that samples the final pattern bit with `in_valid`=1.
- `match_count` increments on the same edge that sets `out`.
- No combinational path from inputs to `out`.
- `in` is ignored whenever `in_valid`=0.

## Configuration
- Macro: `SEQ_DETECT_COUNT_EN`.
- **Defined:**
  - `match_count` increments by 1 on every match.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It clears only on `reset`.
- **Undefined:** `match_count` is tied to 0 and no counter flops are inferred. All other behaviour is identical.

## Test plan
All scenarios use PATTERN=4'b1011, PATTERN_LEN=4, with `in_valid`=1 every cycle unless stated.

1. **Overlapping detection.** OVERLAP=1, stream 1,0,1,1,0,1,1 → `state` 1,2,3,1,2,3,1; `out` pulses after the 4th and 7th bits; `match_count`=2 (macro defined).
2. **Non-overlapping detection.** OVERLAP=0, same stream → `state` 1,2,3,0,0,1,1; exactly one `out` pulse, after the 4th bit.
3. **KMP fallback and qualifier gaps.** Stream 1,1,0,1,1 with `in_valid`=0 inserted between each bit → `state` holds during gaps; sequence 1,1,2,3, then match with `out`=1 for one cycle only.
4. **Reset mid-operation.** Feed 1,0,1 (`state`=3), assert `reset` for one cycle with `in`=1, `in_valid`=1 → `state`=0, no `out` pulse, `match_count`=0.
5. **Counter saturation.** CNT_W=2, macro defined, 5 consecutive overlapping matches → `match_count` reaches 3 and stays 3. With the macro undefined → `match_count`=0 throughout.
6. **Reference check.** Random 2000-bit stream with random `in_valid` → `out` and `state` match a behavioural sliding-window reference model every cycle.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial bit-pattern detector with a KMP-style transition function.
//
// The automaton tracks how many leading bits of PATTERN are currently matched. The whole
// transition function (next count and match flag for every state/bit pair) is evaluated at
// elaboration time, so the runtime logic is only a constant lookup indexed by state and input.
//
// Parameters:
//   PATTERN_LEN  pattern length in bits (>= 2)
//   PATTERN      pattern; PATTERN[PATTERN_LEN-1] is the first bit expected
//   OVERLAP      1: overlapping matches, 0: restart from empty after a match
//   CNT_W        width of match_count
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in           serial data bit
//   in_valid     in is consumed on this edge
//   state        registered count of matched pattern bits
//   next_state   combinational next value of state
//   out          registered one-cycle match pulse
//   match_count  saturating match counter
//
// Build option: define SEQ_DETECT_COUNT_EN to enable the saturating match counter; when it is
// undefined match_count is tied to zero and no counter flops exist.
module seq_detect_fsm #(
    parameter int unsigned              PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]   PATTERN     = 4'b1011,
    parameter int unsigned              OVERLAP     = 1,
    parameter int unsigned              CNT_W       = 8,
    localparam int unsigned             ST_W        = $clog2(PATTERN_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              in_valid,
    output logic [ST_W-1:0]   state,
    output logic [ST_W-1:0]   next_state,
    output logic              out,
    output logic [CNT_W-1:0]  match_count
);

    localparam int unsigned NumSt = 1 << ST_W;

    // Pattern bit i counted from the first (most significant) bit.
    function automatic logic pat_bit(input int unsigned i);
        return 1'(PATTERN >> (PATTERN_LEN - 1 - i));
    endfunction

    // Longest suffix of (first k pattern bits followed by b) that is also a proper prefix of
    // PATTERN. For the full-match case this is the longest border of PATTERN.
    function automatic int unsigned calc_next(input int unsigned k, input int unsigned b);
        int unsigned cap;
        int unsigned pos;
        int unsigned best;
        logic        sbit;
        logic        ok;
        cap  = (k + 1 < PATTERN_LEN) ? k + 1 : PATTERN_LEN - 1;
        best = 0;
        for (int unsigned len = 1; len <= cap; len++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < len; i++) begin
                pos  = k + 1 - len + i;
                sbit = (pos < k) ? pat_bit(pos) : (b != 0);
                if (sbit != pat_bit(i)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = len;
            end
        end
        return best;
    endfunction

    // Constant transition tables; unreachable encodings fall back to the empty state.
    logic [ST_W-1:0] nxt_tab [NumSt][2];
    logic            hit_tab [NumSt][2];

    for (genvar k = 0; k < NumSt; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam bit          Reach = (k < PATTERN_LEN);
            localparam bit          Hit   = Reach && (k == PATTERN_LEN - 1) &&
                                            (pat_bit(k) == (b == 1));
            localparam int unsigned Fb    = calc_next(k, b);
            localparam int unsigned Nxt   = !Reach ? 0 : (Hit && OVERLAP == 0) ? 0 : Fb;
            assign nxt_tab[k][b] = ST_W'(Nxt);
            assign hit_tab[k][b] = Hit;
        end
    end

    logic [ST_W-1:0] state_q, state_d;
    logic            out_q;
    logic            match_d;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= match_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (in_valid) begin
            state_d = nxt_tab[state_q][in];
            match_d = hit_tab[state_q][in];
        end
    end

    // Outputs.
    always_comb begin
        state      = state_q;
        next_state = state_d;
        out        = out_q;
    end

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboard bench for seq_detect_fsm (PATTERN=4'b1011). Three instances share one stimulus
// stream: overlapping (CNT_W=8), non-overlapping (CNT_W=8) and overlapping with CNT_W=2.
module tb_seq_detect_fsm;

`ifdef SEQ_DETECT_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in = 1'b0;
    logic in_valid = 1'b0;

    logic [1:0] st_ov, ns_ov, st_no, ns_no, st_sat, ns_sat;
    logic       out_ov, out_no, out_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    always #5 clk = ~clk;

    seq_detect_fsm #(.OVERLAP(1)) dut_ov (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .state(st_ov), .next_state(ns_ov), .out(out_ov), .match_count(cnt_ov)
    );

    seq_detect_fsm #(.OVERLAP(0)) dut_no (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .state(st_no), .next_state(ns_no), .out(out_no), .match_count(cnt_no)
    );

    seq_detect_fsm #(.OVERLAP(1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .state(st_sat), .next_state(ns_sat), .out(out_sat), .match_count(cnt_sat)
    );

    typedef struct {
        int         id;
        logic [1:0] st_ov;
        logic [1:0] st_no;
        logic       out_ov;
        logic       out_no;
        logic [7:0] cnt_ov;
        logic [7:0] cnt_no;
        logic [1:0] cnt_sat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   step_id = 0;
    int   n_ov = 0;
    int   n_no = 0;
    int   n_sat = 0;

    // Sliding-window reference state, index 0 = overlapping, 1 = non-overlapping.
    logic [2:0] m_hist [2];
    int         m_len  [2];
    logic [1:0] m_st   [2];

    task automatic chk(input string nm, input int id, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    function automatic logic [7:0] ecnt(input int n);
        return CountEn ? 8'(n) : 8'd0;
    endfunction

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("state_ov",  e.id, 8'(st_ov),   8'(e.st_ov));
                chk("out_ov",    e.id, 8'(out_ov),  8'(e.out_ov));
                chk("count_ov",  e.id, cnt_ov,      e.cnt_ov);
                chk("state_no",  e.id, 8'(st_no),   8'(e.st_no));
                chk("out_no",    e.id, 8'(out_no),  8'(e.out_no));
                chk("count_no",  e.id, cnt_no,      e.cnt_no);
                chk("state_sat", e.id, 8'(st_sat),  8'(e.st_ov));
                chk("out_sat",   e.id, 8'(out_sat), 8'(e.out_ov));
                chk("count_sat", e.id, 8'(cnt_sat), 8'(e.cnt_sat));
            end
        end
    end

    // Drive one cycle and push the expected post-edge response.
    task automatic step(input logic r, input logic i, input logic v,
                        input logic [1:0] so, input logic oo,
                        input logic [1:0] sn, input logic on);
        exp_t e;
        @(negedge clk);
        reset    = r;
        in       = i;
        in_valid = v;
        if (r) begin
            n_ov  = 0;
            n_no  = 0;
            n_sat = 0;
        end else begin
            if (oo && n_ov < 255) n_ov++;
            if (oo && n_sat < 3) n_sat++;
            if (on && n_no < 255) n_no++;
        end
        e.id      = step_id;
        e.st_ov   = so;
        e.st_no   = sn;
        e.out_ov  = oo;
        e.out_no  = on;
        e.cnt_ov  = ecnt(n_ov);
        e.cnt_no  = ecnt(n_no);
        e.cnt_sat = 2'(ecnt(n_sat));
        q.push_back(e);
        step_id++;
        #1;
        if (!r) begin
            chk("next_state_ov", e.id, 8'(ns_ov), 8'(so));
            chk("next_state_no", e.id, 8'(ns_no), 8'(sn));
        end
    endtask

    task automatic model(input int f, input logic r, input logic i, input logic v,
                         output logic [1:0] st, output logic o);
        logic [3:0] w;
        logic [3:0] pat;
        int         wl;
        int         best;
        pat = 4'b1011;
        o   = 1'b0;
        if (r) begin
            m_hist[f] = '0;
            m_len[f]  = 0;
            m_st[f]   = '0;
        end else if (v) begin
            w  = {m_hist[f], i};
            wl = m_len[f] + 1;
            o  = (wl >= 4) && (w == pat);
            if (o && f == 1) begin
                m_hist[f] = '0;
                m_len[f]  = 0;
                m_st[f]   = '0;
            end else begin
                m_hist[f] = w[2:0];
                m_len[f]  = (wl > 3) ? 3 : wl;
                best = 0;
                for (int j = 1; j <= 3; j++) begin
                    if (j <= m_len[f] && ((w & ((4'd1 << j) - 4'd1)) == (pat >> (4 - j))))
                        best = j;
                end
                m_st[f] = 2'(best);
            end
        end
        st = m_st[f];
    endtask

    task automatic step_m(input logic r, input logic i, input logic v);
        logic [1:0] so, sn;
        logic       oo, on;
        model(0, r, i, v, so, oo);
        model(1, r, i, v, sn, on);
        step(r, i, v, so, oo, sn, on);
    endtask

    initial begin
        int unsigned ri, rv;

        // Overlapping vs non-overlapping on 1,0,1,1,0,1,1.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 1, 2, 0, 2, 0);
        step(0, 1, 1, 3, 0, 3, 0);
        step(0, 1, 1, 1, 1, 0, 1);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 1, 1, 3, 0, 1, 0);
        step(0, 1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);

        // Fallback with qualifier gaps; gap bits must be ignored.
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 2, 0, 2, 0);
        step(0, 1, 0, 2, 0, 2, 0);
        step(0, 1, 1, 3, 0, 3, 0);
        step(0, 1, 0, 3, 0, 3, 0);
        step(0, 1, 1, 1, 1, 0, 1);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // Reset while the last pattern bit is presented.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 1, 2, 0, 2, 0);
        step(0, 1, 1, 3, 0, 3, 0);
        step(0, 1, 1, 1, 1, 0, 1);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 1, 1, 3, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);

        // Five back-to-back overlapping matches; 2-bit counter saturates at 3.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 1, 2, 0, 2, 0);
        step(0, 1, 1, 3, 0, 3, 0);
        step(0, 1, 1, 1, 1, 0, 1);
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) begin
                step(0, 0, 1, 2, 0, 0, 0);
                step(0, 1, 1, 3, 0, 1, 0);
                step(0, 1, 1, 1, 1, 1, 0);
            end else begin
                step(0, 0, 1, 2, 0, 2, 0);
                step(0, 1, 1, 3, 0, 3, 0);
                step(0, 1, 1, 1, 1, 0, 1);
            end
        end
        step(0, 0, 0, 1, 0, 0, 0);

        // Random stream against the sliding-window reference.
        step_m(1, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            ri = $urandom_range(0, 1);
            rv = $urandom_range(0, 9);
            step_m(0, ri[0], rv < 7);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
